// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage register bundle: ID-side inputs, WB bypass,
// pipeline controls and the registered EX-side outputs.
interface id_ex_stage_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [6:0]       id_opcode;
  logic [2:0]       id_func3;
  logic [3:0]       id_alu_op;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic             id_reg_file_wr;
  logic             id_mem_rd;
  logic             id_mem_wr;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             reg_file_wr_wb;
  logic             mem_stall;
  logic             flush_ex;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_func3;
  logic [3:0]       ex_alu_op;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic             ex_reg_file_wr;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic             stall_id;
  logic [CNT_W-1:0] lu_bubble_cnt;

  modport master (
    output id_valid, id_pc, id_opcode, id_func3, id_alu_op,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_file_wr, id_mem_rd, id_mem_wr,
           wb_rd, wb_data, reg_file_wr_wb, mem_stall, flush_ex,
    input  ex_valid, ex_pc, ex_imm, ex_opcode, ex_func3,
           ex_alu_op, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_reg_file_wr, ex_mem_rd, ex_mem_wr,
           stall_id, lu_bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_opcode, id_func3, id_alu_op,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_file_wr, id_mem_rd, id_mem_wr,
           wb_rd, wb_data, reg_file_wr_wb, mem_stall, flush_ex,
    output ex_valid, ex_pc, ex_imm, ex_opcode, ex_func3,
           ex_alu_op, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_reg_file_wr, ex_mem_rd, ex_mem_wr,
           stall_id, lu_bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion,
// WB bypass into captured operands and a bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_JTYPE = 7'b1101111;
  localparam logic [6:0] OP_UTYPE = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rf_wr;
    logic            mem_rd;
    logic            mem_wr;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uses_rs1, uses_rs2;
  logic             load_use;
  logic             byp1, byp2;

  // Source-use decode and load-use hazard against the load in EX
  always_comb begin
    uses_rs1 = !(bus.id_opcode == OP_JTYPE ||
                 bus.id_opcode == OP_UTYPE ||
                 bus.id_opcode == OP_AUIPC);
    uses_rs2 = bus.id_opcode == OP_RTYPE ||
               bus.id_opcode == OP_BTYPE ||
               bus.id_opcode == OP_STYPE;
    load_use = ex_q.valid && ex_q.mem_rd &&
               ex_q.rd != 5'd0 && bus.id_valid &&
               ((uses_rs1 && bus.id_rs1 == ex_q.rd) ||
                (uses_rs2 && bus.id_rs2 == ex_q.rd));
    byp1 = bus.reg_file_wr_wb && bus.wb_rd != 5'd0 &&
           bus.wb_rd == bus.id_rs1;
    byp2 = bus.reg_file_wr_wb && bus.wb_rd != 5'd0 &&
           bus.wb_rd == bus.id_rs2;
  end

  // Next-state: hold > flush bubble > load-use bubble > capture
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.mem_stall) begin
      ex_d = ex_q;
    end else if (bus.flush_ex) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.pc       = bus.id_pc;
      ex_d.imm      = bus.id_imm;
      ex_d.opcode   = bus.id_opcode;
      ex_d.func3    = bus.id_func3;
      ex_d.alu_op   = bus.id_alu_op;
      ex_d.rs1      = bus.id_rs1;
      ex_d.rs2      = bus.id_rs2;
      ex_d.rd       = bus.id_rd;
      ex_d.rs1_data = byp1 ? bus.wb_data : bus.id_rs1_data;
      ex_d.rs2_data = byp2 ? bus.wb_data : bus.id_rs2_data;
      ex_d.rf_wr    = bus.id_reg_file_wr;
      ex_d.mem_rd   = bus.id_mem_rd;
      ex_d.mem_wr   = bus.id_mem_wr;
    end
  end

  // EX register and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_id       = bus.mem_stall ||
                              (load_use && !bus.flush_ex);
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_opcode      = ex_q.opcode;
  assign bus.ex_func3       = ex_q.func3;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_rs1         = ex_q.rs1;
  assign bus.ex_rs2         = ex_q.rs2;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rs1_data    = ex_q.rs1_data;
  assign bus.ex_rs2_data    = ex_q.rs2_data;
  assign bus.ex_reg_file_wr = ex_q.rf_wr;
  assign bus.ex_mem_rd      = ex_q.mem_rd;
  assign bus.ex_mem_wr      = ex_q.mem_wr;
  assign bus.lu_bubble_cnt  = cnt_q;
endmodule
